// File: rtl/truth_table_scanner.sv
// Drives all four minterms of a two-input gate and captures its truth table.
// Optional registered popcount of the table: define SCANNER_ONES_COUNT_EN.
module truth_table_scanner (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       s_in_i,
   output logic       a_o,
   output logic       b_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] table_o,
   output logic [2:0] ones_o
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0] state_q, state_d;
   logic [1:0] m_q, m_d;
   logic [3:0] table_q, table_d;
   logic       clear_scan;
   logic       sample_en;

   assign clear_scan = ((state_q == IDLE) || (state_q == DONE)) && start_i;
   assign sample_en  = (state_q == SAMPLE);

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      table_d = table_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d = DRIVE;
               m_d     = '0;
               table_d = '0;
            end
         end
         DRIVE: begin
            state_d = SAMPLE;
         end
         SAMPLE: begin
            table_d[m_q] = s_in_i;
            if (m_q == 2'd3) begin
               state_d = DONE;
            end else begin
               m_d     = m_q + 2'd1;
               state_d = DRIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         m_q     <= '0;
         table_q <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         table_q <= table_d;
      end
   end

   // Gate inputs follow m only while scanning; they park at 00 otherwise.
   assign busy_o  = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done_o  = (state_q == DONE);
   assign a_o     = busy_o & m_q[1];
   assign b_o     = busy_o & m_q[0];
   assign table_o = table_q;

`ifdef SCANNER_ONES_COUNT_EN
   logic [2:0] ones_q, ones_d;

   // Unsampled bits are always 0, so accumulating each sample tracks popcount.
   always_comb begin
      ones_d = ones_q;
      if (clear_scan) begin
         ones_d = '0;
      end else if (sample_en) begin
         ones_d = ones_q + {2'b00, s_in_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ones_q <= '0;
      end else begin
         ones_q <= ones_d;
      end
   end

   assign ones_o = ones_q;
`else
   assign ones_o = '0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner; the gate under test is a
// randomizable 4-entry lookup, so the expected table is the lookup itself.
module tb_truth_table_scanner;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       s_in;
   logic [3:0] gate_tt;
   logic       a, b, busy, done;
   logic [3:0] tbl;
   logic [2:0] ones;

   int unsigned errors = 0;
   int unsigned checks = 0;

   truth_table_scanner dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .s_in_i  (s_in),
      .a_o     (a),
      .b_o     (b),
      .busy_o  (busy),
      .done_o  (done),
      .table_o (tbl),
      .ones_o  (ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign s_in = gate_tt[{a, b}];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_ones(input logic [3:0] t);
`ifdef SCANNER_ONES_COUNT_EN
      return 3'($countones(t));
`else
      return 3'd0;
`endif
   endfunction

   // Edge k counts from the edge that samples start; the minterm on the
   // gate during edges 2j+1..2j+2 is j, and after edge k (k-1)/2 bits are in.
   task automatic scan(input logic [3:0] tt, input bit hold);
      int         n;
      logic [3:0] part;
      logic [1:0] idx;
      @(negedge clk);
      gate_tt = tt;
      start   = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         n    = (k - 1) / 2;
         part = tt & 4'((1 << n) - 1);
         idx  = (k <= 8) ? 2'((k - 1) / 2) : 2'd0;
         check($sformatf("ab_e%0d", k), {6'd0, a, b}, {6'd0, idx});
         check($sformatf("busy_e%0d", k), {7'd0, busy}, {7'd0, (k <= 8)});
         check($sformatf("done_e%0d", k), {7'd0, done}, {7'd0, (k == 9)});
         check($sformatf("table_e%0d", k), {4'd0, tbl}, {4'd0, part});
         check($sformatf("ones_e%0d", k), {5'd0, ones}, {5'd0, exp_ones(part)});
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ab"}, {6'd0, a, b}, 8'd0);
      check({tag, "_busy"}, {7'd0, busy}, 8'd0);
      check({tag, "_done"}, {7'd0, done}, 8'd0);
      check({tag, "_table"}, {4'd0, tbl}, 8'd0);
      check({tag, "_ones"}, {5'd0, ones}, 8'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      gate_tt = 4'b0000;
      #2;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Idle without start must stay idle.
      repeat (3) begin
         @(posedge clk);
         #1;
         check_all_zero("idle");
      end

      // b & ~a, a & b, constant 1.
      scan(4'b0010, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("done_hold", {7'd0, done}, 8'd1);
         check("table_hold", {4'd0, tbl}, 8'h02);
      end
      scan(4'b1000, 1'b0);
      scan(4'b1111, 1'b0);

      repeat (6) scan(4'($urandom), 1'b0);

      // Start held through a scan is ignored; still high in DONE restarts it.
      scan(4'b1111, 1'b1);
      scan(4'b0110, 1'b0);

      // Reset mid-scan, after edge 5.
      @(negedge clk);
      gate_tt = 4'b1011;
      start   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check("pre_rst_busy", {7'd0, busy}, 8'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      scan(4'b1011, 1'b0);
      scan(4'($urandom), 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
